ulaw_encode_writer: RTL and testbench

ULAW_ENCODE_WRITER -- requirements
Module: ulaw_encode_writer

---
 rtl/ulaw_encode_writer.sv | 135 +++++++++++++
 tb/tb_ulaw_encode_writer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ulaw_encode_writer.sv
// Streams LEN signed 16-bit linear samples from a source memory, mu-law encodes
// each one and writes the bytes to a destination memory at one sample per cycle.
module ulaw_encode_writer #(
   parameter int unsigned            ADDR_WIDTH    = 16,
   parameter logic [ADDR_WIDTH-1:0]  ADDR_BASE_SRC = '0,
   parameter logic [ADDR_WIDTH-1:0]  ADDR_BASE_DST = '0,
   parameter int unsigned            LEN           = 784
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    reset,
   output logic                    done,
   output logic [ADDR_WIDTH-1:0]   src_addr,
   input  logic signed [15:0]      src_data,
   output logic                    dst_we,
   output logic [ADDR_WIDTH-1:0]   dst_addr,
   output logic [7:0]              dst_data
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
   logic                    flush_q, flush_d;
   logic [ADDR_WIDTH-1:0]   src_addr_q, src_addr_d;
   logic                    s1_vld_q, s1_vld_d;
   logic signed [15:0]      s1_data_q, s1_data_d;
   logic [ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
   logic                    dst_we_q, dst_we_d;
   logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
   logic [7:0]              dst_data_q, dst_data_d;
   logic                    done_q, done_d;

   // Magnitude is formed in 17 bits so -32768 does not overflow before clipping.
   function automatic logic [7:0] ulaw_enc(input logic signed [15:0] x);
      logic [16:0] mag;
      logic [12:0] b;
      logic [2:0]  e;
      logic [3:0]  m;
      mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
      if (mag > 17'd8158) mag = 17'd8158;
      b = 13'(mag + 17'd33);
      e = 3'd0;
      for (int p = 5; p <= 12; p++) begin
         if (b[p]) e = 3'(p - 5);
      end
      m = 4'(b >> (4'(e) + 4'd1));
      return {x[15], e, m};
   endfunction

   always_comb begin
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      flush_d    = flush_q;
      src_addr_d = src_addr_q;
      done_d     = done_q;

      // Two-stage datapath: capture sample, then encode and write.
      s1_vld_d   = (state_q == S_RUN);
      s1_data_d  = src_data;
      s1_addr_d  = ADDR_BASE_DST + rd_cnt_q;
      dst_we_d   = s1_vld_q;
      dst_addr_d = s1_vld_q ? s1_addr_q : dst_addr_q;
      dst_data_d = s1_vld_q ? ulaw_enc(s1_data_q) : dst_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RUN;
               rd_cnt_d   = '0;
               src_addr_d = ADDR_BASE_SRC;
            end
         end
         S_RUN: begin
            if (rd_cnt_q == LAST_IDX) begin
               state_d    = S_FLUSH;
               flush_d    = 1'b0;
               src_addr_d = ADDR_BASE_SRC;
            end else begin
               rd_cnt_d   = rd_cnt_q + ONE;
               src_addr_d = ADDR_BASE_SRC + rd_cnt_q + ONE;
            end
         end
         S_FLUSH: begin
            if (flush_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               flush_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Hard reset and soft clear have identical effect and beat any start request.
   always_ff @(posedge clk) begin
      if (rst || reset) begin
         state_q    <= S_IDLE;
         rd_cnt_q   <= '0;
         flush_q    <= 1'b0;
         src_addr_q <= ADDR_BASE_SRC;
         s1_vld_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_addr_q  <= '0;
         dst_we_q   <= 1'b0;
         dst_addr_q <= '0;
         dst_data_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         flush_q    <= flush_d;
         src_addr_q <= src_addr_d;
         s1_vld_q   <= s1_vld_d;
         s1_data_q  <= s1_data_d;
         s1_addr_q  <= s1_addr_d;
         dst_we_q   <= dst_we_d;
         dst_addr_q <= dst_addr_d;
         dst_data_q <= dst_data_d;
         done_q     <= done_d;
      end
   end

   assign done     = done_q;
   assign src_addr = src_addr_q;
   assign dst_we   = dst_we_q;
   assign dst_addr = dst_addr_q;
   assign dst_data = dst_data_q;

endmodule

// File: tb/tb_ulaw_encode_writer.sv
// Bench for ulaw_encode_writer: 4-sample runs with a wrapping destination base,
// random and corner-case samples, aborts, re-pulsed starts and reset/start races.
module tb_ulaw_encode_writer;

   localparam int unsigned      AW  = 16;
   localparam int unsigned      LEN = 4;
   localparam logic [AW-1:0]    BS  = 16'h0100;
   localparam logic [AW-1:0]    BD  = 16'hFFFE;

   logic               clk, rst, start, reset, done, dst_we;
   logic [AW-1:0]      src_addr, dst_addr;
   logic signed [15:0] src_data;
   logic [7:0]         dst_data;

   logic signed [15:0] mem [4];
   logic [AW-1:0]      off;

   int n_chk  = 0;
   int n_pass = 0;

   ulaw_encode_writer #(
      .ADDR_WIDTH(AW), .ADDR_BASE_SRC(BS), .ADDR_BASE_DST(BD), .LEN(LEN)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .reset(reset), .done(done),
      .src_addr(src_addr), .src_data(src_data), .dst_we(dst_we),
      .dst_addr(dst_addr), .dst_data(dst_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source memory: four samples at BS..BS+3, a marker value elsewhere.
   always_comb begin
      off = src_addr - BS;
      src_data = (off < 16'd4) ? mem[off[1:0]] : 16'sh7777;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
   endtask

   // Reference mu-law: clip, bias, find segment by doubling thresholds.
   function automatic int ref_enc(input int v);
      int s, mag, b, e;
      s   = (v < 0) ? 1 : 0;
      mag = (v < 0) ? -v : v;
      if (mag > 8158) mag = 8158;
      b = mag + 33;
      e = 0;
      while (b >= (64 << e)) e++;
      return s * 128 + e * 16 + ((b >> (e + 1)) % 16);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_src_addr"}, 32'(src_addr), 32'(BS));
      check({tag, "_we"}, 32'(dst_we), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Full run, with cycle n meaning the n-th negedge after the start edge.
   task automatic do_run(input bit repulse);
      logic [AW-1:0] a;
      bit we_e;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         we_e = (n >= 3 && n <= 6);
         a = (n <= 4) ? BS + 16'(n - 1) : BS;
         check("src_addr", 32'(src_addr), 32'(a));
         check("dst_we", 32'(dst_we), 32'(we_e));
         if (we_e) begin
            a = BD + 16'(n - 3);
            check("dst_addr", 32'(dst_addr), 32'(a));
            check("dst_data", 32'(dst_data), 32'(ref_enc(int'(mem[n - 3]))));
         end
         check("done", 32'(done), 32'(n >= 7));
         start = repulse && (n == 2 || n == 5 || n == 9);
         @(negedge clk);
      end
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("done_clr", 32'(done), 32'd0);
      check("we_clr", 32'(dst_we), 32'd0);
   endtask

   function automatic logic signed [15:0] pick_sample();
      logic [15:0] corner [8];
      corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'd8158, 16'd8159, 16'hE021, 16'd31};
      if ($urandom_range(3) == 0) return corner[$urandom_range(7)];
      return 16'($urandom);
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; reset = 1'b0;
      mem = '{16'sd0, -16'sd1, 16'sd100, 16'sd8158};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_dst_addr", 32'(dst_addr), 32'd0);
      check("rst_dst_data", 32'(dst_data), 32'd0);
      check_idle("rst");

      do_run(1'b0);
      mem = '{16'sh7FFF, 16'sh8000, -16'sd8159, 16'sd8159};
      do_run(1'b1);

      // Abort after two writes, then restart.
      mem = '{16'sd1234, -16'sd4321, 16'sd77, -16'sd300};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         check("ab_we", 32'(dst_we), 32'(n >= 3));
         if (n == 4) reset = 1'b1;
         @(negedge clk);
      end
      reset = 1'b0;
      for (int n = 5; n <= 12; n++) begin
         check_idle("abort");
         @(negedge clk);
      end
      do_run(1'b0);

      // Start and reset together: reset wins.
      start = 1'b1; reset = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      for (int n = 0; n < 6; n++) begin
         check_idle("race");
         @(negedge clk);
      end

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 4; i++) mem[i] = pick_sample();
         do_run(bit'($urandom_range(1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
